uart_instr_responder: RTL and testbench

- Far end of the instruction-fetch UART link: receives a 32-bit address word on rx, fetches the word at that address from a memory-side handshake port, and returns the 32-bit data word on tx.
- Sits next to instruction ROM/RAM (board or testbench side); pairs with the core-side fetch interface so the core can boot and run from external memory over a serial line.
- Single clock domain; baud timing is generated internally from a clock-enable counter, not from a divided clock.

---
 rtl/uart_instr_responder.sv | 264 ++++++++++++++++++++++++++
 tb/tb_uart_instr_responder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_instr_responder.sv
// Serial instruction responder: receives a 32-bit little-endian address over
// an 8N1 UART line, fetches that word through a req/ack memory port and sends
// the 32-bit data word back, little-endian, on tx. Half-duplex.
module uart_instr_responder #(
  parameter int CLKS_PER_BIT = 163,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        tx,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int GW = $clog2(TIMEOUT_BITS + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(TIMEOUT_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RX_START = 3'd1,
    S_RX_DATA  = 3'd2,
    S_RX_STOP  = 3'd3,
    S_RX_GAP   = 3'd4,
    S_MEM      = 3'd5,
    S_TX       = 3'd6
  } state_t;

  state_t          r_state, w_next;
  logic            r_rx_meta, r_rx_s;
  logic [CW-1:0]   r_baud;
  logic            w_strobe, w_half;
  logic            r_armed;
  logic [CW-1:0]   r_arm_cnt;
  logic            r_from_gap;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic [23:0]     r_addr_shadow;
  logic [1:0]      r_idx;
  logic [GW-1:0]   r_gap_cnt;
  logic [31:0]     r_tx_sh;
  logic [3:0]      r_tx_bit;
  logic [1:0]      r_tx_byte;
  logic            w_tx_val, w_busy, w_ferr, w_req;
  logic            r_tx, r_busy, r_frame_err, r_mem_req;
  logic [31:0]     r_mem_addr;

  assign w_strobe = (r_baud == BAUD_LAST);
  assign w_half   = (r_baud == BAUD_HALF);

  // Two-flop synchronizer for the asynchronous rx line (idles high).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Baud counter: wraps at the terminal count and restarts on every state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_baud <= '0;
    end else if ((w_next != r_state) || w_strobe) begin
      r_baud <= '0;
    end else begin
      r_baud <= r_baud + CW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_armed && !r_rx_s) w_next = S_RX_START;
        else                    w_next = S_IDLE;
      end
      S_RX_START: begin
        if (w_half) begin
          if (!r_rx_s)         w_next = S_RX_DATA;
          else if (r_from_gap) w_next = S_RX_GAP;
          else                 w_next = S_IDLE;
        end else begin
          w_next = S_RX_START;
        end
      end
      S_RX_DATA: begin
        if (w_strobe && (r_bit == 3'd7)) w_next = S_RX_STOP;
        else                             w_next = S_RX_DATA;
      end
      S_RX_STOP: begin
        if (!w_strobe)             w_next = S_RX_STOP;
        else if (!r_rx_s)          w_next = S_IDLE;
        else if (r_idx == 2'd3)    w_next = S_MEM;
        else                       w_next = S_RX_GAP;
      end
      S_RX_GAP: begin
        if (!r_rx_s)                                w_next = S_RX_START;
        else if (w_strobe && (r_gap_cnt == GAP_LAST)) w_next = S_IDLE;
        else                                        w_next = S_RX_GAP;
      end
      S_MEM: begin
        if (mem_ack) w_next = S_TX;
        else         w_next = S_MEM;
      end
      S_TX: begin
        if (w_strobe && (r_tx_bit == 4'd9) && (r_tx_byte == 2'd3)) w_next = S_IDLE;
        else                                                     w_next = S_TX;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FSM output decode; busy stays up through the final tx cycle of the last stop bit.
  always_comb begin
    w_tx_val = 1'b1;
    w_ferr   = 1'b0;
    w_busy   = (w_next != S_IDLE) || (r_state == S_TX);
    w_req    = (w_next == S_MEM);
    case (r_state)
      S_RX_STOP: begin
        if (w_strobe && !r_rx_s) w_ferr = 1'b1;
        else                     w_ferr = 1'b0;
      end
      S_RX_GAP: begin
        if (r_rx_s && w_strobe && (r_gap_cnt == GAP_LAST)) w_ferr = 1'b1;
        else                                              w_ferr = 1'b0;
      end
      S_TX: begin
        if (r_tx_bit == 4'd0)      w_tx_val = 1'b0;
        else if (r_tx_bit == 4'd9) w_tx_val = 1'b1;
        else                       w_tx_val = r_tx_sh[0];
      end
      default: w_tx_val = 1'b1;
    endcase
  end

  // Registered copies of the decoded outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_mem_req   <= 1'b0;
    end else begin
      r_tx        <= w_tx_val;
      r_busy      <= w_busy;
      r_frame_err <= w_ferr;
      r_mem_req   <= w_req;
    end
  end

  // Re-arm qualifier: after leaving an active phase, rx must stay high a full bit-time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed   <= 1'b0;
      r_arm_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (!r_rx_s)                     r_arm_cnt <= '0;
      else if (r_arm_cnt == BAUD_LAST) r_armed   <= 1'b1;
      else                             r_arm_cnt <= r_arm_cnt + CW'(1);
    end else if ((w_next == S_IDLE) && (r_state != S_RX_START)) begin
      r_armed   <= 1'b0;
      r_arm_cnt <= '0;
    end
  end

  // Inter-byte idle counter in bit-times.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gap_cnt <= '0;
    end else if (r_state != S_RX_GAP) begin
      r_gap_cnt <= '0;
    end else if (w_strobe) begin
      r_gap_cnt <= r_gap_cnt + GW'(1);
    end
  end

  // Receive datapath: bit shifting, byte assembly and address load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_from_gap    <= 1'b0;
      r_bit         <= 3'd0;
      r_shift       <= 8'd0;
      r_addr_shadow <= 24'd0;
      r_idx         <= 2'd0;
      r_mem_addr    <= 32'd0;
    end else begin
      if ((r_state != S_RX_START) && (w_next == S_RX_START)) begin
        r_from_gap <= (r_state == S_RX_GAP);
      end
      if (r_state != S_RX_DATA) begin
        r_bit <= 3'd0;
      end else if (w_strobe) begin
        r_shift <= {r_rx_s, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
      if ((r_state == S_RX_STOP) && w_strobe) begin
        if (!r_rx_s) begin
          r_idx <= 2'd0;
        end else begin
          r_idx <= r_idx + 2'd1;
          case (r_idx)
            2'd0:    r_addr_shadow[7:0]   <= r_shift;
            2'd1:    r_addr_shadow[15:8]  <= r_shift;
            2'd2:    r_addr_shadow[23:16] <= r_shift;
            default: r_mem_addr <= {r_shift, r_addr_shadow};
          endcase
        end
      end else if ((r_state == S_RX_GAP) && (w_next == S_IDLE)) begin
        r_idx <= 2'd0;
      end
    end
  end

  // Transmit datapath: the whole word shifts out LSB first, giving little-endian bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_sh   <= 32'd0;
      r_tx_bit  <= 4'd0;
      r_tx_byte <= 2'd0;
    end else if ((r_state == S_MEM) && mem_ack) begin
      r_tx_sh   <= mem_rdata;
      r_tx_bit  <= 4'd0;
      r_tx_byte <= 2'd0;
    end else if ((r_state == S_TX) && w_strobe) begin
      if ((r_tx_bit != 4'd0) && (r_tx_bit != 4'd9)) begin
        r_tx_sh <= {1'b0, r_tx_sh[31:1]};
      end
      if (r_tx_bit == 4'd9) begin
        r_tx_bit  <= 4'd0;
        r_tx_byte <= r_tx_byte + 2'd1;
      end else begin
        r_tx_bit <= r_tx_bit + 4'd1;
      end
    end
  end

  assign tx        = r_tx;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_uart_instr_responder.sv
// Self-checking bench for uart_instr_responder: table-driven fetches,
// hand-written corner sequences and randomized fetches against a reference model.
module tb_uart_instr_responder;

  localparam int CPB = 16;
  localparam int TOB = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        tx;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        frame_err;

  int   n_checks  = 0;
  int   n_err     = 0;
  int   ferr_cnt  = 0;
  int   req_rises = 0;
  logic req_d     = 1'b0;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] rdata;
    int          delay;
    bit          toggle;
    logic [31:0] exp_addr;
    logic [31:0] exp_tx;
  } vec_t;

  vec_t vecs [4];

  uart_instr_responder #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .tx        (tx),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Count frame_err high cycles and mem_req rising edges, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt++;
    if (mem_req === 1'b1 && req_d !== 1'b1) req_rises++;
    req_d = mem_req;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: address is the four received bytes, byte 0 least significant.
  function automatic logic [31:0] model_addr(input logic [7:0] b0, b1, b2, b3);
    longint unsigned a;
    a = longint'(b0) + 256 * longint'(b1) + 65536 * longint'(b2) + 16777216 * longint'(b3);
    return 32'(a);
  endfunction

  // Reference model: tx level at cycle c after the first start-bit edge.
  function automatic logic model_tx_bit(input logic [31:0] word, input int c);
    int bit_no, byte_no, pos;
    bit_no  = c / CPB;
    byte_no = bit_no / 10;
    pos     = bit_no % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return ((word >> (8 * byte_no + pos - 1)) & 32'd1) != 32'd0;
  endfunction

  // Drive one 8N1 frame; entered and left at posedge+1.
  task automatic send_byte(input logic [7:0] b, input logic stop_b);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop_b;
    repeat (CPB) @(posedge clk);
    #1;
    rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input string tag, input logic [7:0] b0, b1, b2, b3,
                          input logic [31:0] rdata, input int delay, input bit toggle,
                          input logic [31:0] exp_addr, input logic [31:0] exp_tx);
    int f0, r0, waited, bad_req, bad_cyc, bitpos, k;
    logic [7:0] dec;
    idle_bits(2);
    f0 = ferr_cnt;
    r0 = req_rises;
    send_byte(b0, 1'b1);
    check({tag, "_busy_rx"}, 32'(busy), 32'd1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
    waited = 0;
    while (mem_req !== 1'b1 && waited < 64) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (mem_req !== 1'b1) begin
      check({tag, "_req_timeout"}, 32'(mem_req), 32'd1);
      return;
    end
    check({tag, "_addr"}, mem_addr, exp_addr);
    bad_req = 0;
    for (int d = 0; d < delay; d++) begin
      if (toggle && d < delay - 20) rx = d[2];
      else rx = 1'b1;
      @(posedge clk);
      #1;
      if (mem_req !== 1'b1 || mem_addr !== exp_addr) bad_req++;
    end
    rx = 1'b1;
    if (delay > 0) check({tag, "_req_hold"}, 32'(bad_req), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = ~rdata;
    check({tag, "_req_drop"}, 32'(mem_req), 32'd0);
    check({tag, "_tx_pre"}, 32'(tx), 32'd1);
    bad_cyc = 0;
    dec = 8'd0;
    for (int c = 0; c < 40 * CPB; c++) begin
      @(posedge clk);
      #1;
      mem_ack = (c == 50);
      if (tx !== model_tx_bit(rdata, c)) bad_cyc++;
      if ((c % CPB) == CPB / 2) begin
        bitpos = (c / CPB) % 10;
        if (bitpos >= 1 && bitpos <= 8) dec[bitpos - 1] = tx;
      end
      if ((c % (10 * CPB)) == 10 * CPB - 1) begin
        k = c / (10 * CPB);
        check({tag, "_txbyte"}, 32'(dec), 32'(exp_tx[8 * k +: 8]));
      end
      if (c == 40 * CPB - 1) check({tag, "_busy_last"}, 32'(busy), 32'd1);
    end
    mem_ack = 1'b0;
    check({tag, "_tx_timing"}, 32'(bad_cyc), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_tx_idle"}, 32'(tx), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_no_ferr"}, 32'(ferr_cnt - f0), 32'd0);
    check({tag, "_one_req"}, 32'(req_rises - r0), 32'd1);
  endtask

  initial begin
    int f0, r0, first, waited;
    logic [7:0]  rb0, rb1, rb2, rb3;
    logic [31:0] rd;

    vecs[0] = '{8'h10, 8'h00, 8'h00, 8'h00, 32'hDEADBEEF, 3,   1'b0, 32'h00000010, 32'hDEADBEEF};
    vecs[1] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h12345678, 0,   1'b0, 32'h04030201, 32'h12345678};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'h00000000, 100, 1'b1, 32'hFFFFFFFF, 32'h00000000};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h80, 32'hA5A55A5A, 1,   1'b0, 32'h80000000, 32'hA5A55A5A};

    reset     = 1'b0;
    rx        = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    reset = 1'b1;

    for (int v = 0; v < 4; v++) begin
      do_fetch("vec", vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3, vecs[v].rdata,
               vecs[v].delay, vecs[v].toggle, vecs[v].exp_addr, vecs[v].exp_tx);
    end

    // Framing error: bad stop bit, then a clean word must not pick up the stale byte.
    idle_bits(2);
    f0 = ferr_cnt;
    r0 = req_rises;
    send_byte(8'h04, 1'b0);
    idle_bits(3);
    check("ferr_stop_pulse", 32'(ferr_cnt - f0), 32'd1);
    check("ferr_stop_noreq", 32'(req_rises - r0), 32'd0);
    check("ferr_stop_busy", 32'(busy), 32'd0);
    do_fetch("after_ferr", 8'h08, 8'h00, 8'h00, 8'h00, 32'hCAFEF00D, 2, 1'b0,
             32'h00000008, 32'hCAFEF00D);

    // Inter-byte timeout after two bytes.
    idle_bits(2);
    f0 = ferr_cnt;
    r0 = req_rises;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    first = -1;
    for (int i = 1; i <= 40 * CPB; i++) begin
      @(negedge clk);
      if (first < 0 && ferr_cnt != f0) first = i;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (first < 498 || first > 518) begin
      n_err++;
      $display("FAIL timeout_at: got cycle %0d required 498..518", first);
    end
    check("timeout_pulse", 32'(ferr_cnt - f0), 32'd1);
    check("timeout_noreq", 32'(req_rises - r0), 32'd0);
    check("timeout_busy", 32'(busy), 32'd0);
    do_fetch("after_to", 8'h01, 8'h02, 8'h03, 8'h04, 32'h0BADC0DE, 5, 1'b0,
             32'h04030201, 32'h0BADC0DE);

    // Glitch: 4-cycle low pulse in idle.
    idle_bits(2);
    f0 = ferr_cnt;
    r0 = req_rises;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    check("glitch_busy_rise", 32'(busy), 32'd1);
    idle_bits(3);
    check("glitch_busy_fall", 32'(busy), 32'd0);
    check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("glitch_no_req", 32'(req_rises - r0), 32'd0);
    do_fetch("after_glitch", 8'h3C, 8'h00, 8'h01, 8'h00, 32'h600DCAFE, 0, 1'b0,
             32'h0001003C, 32'h600DCAFE);

    // Randomized fetches against the reference model.
    for (int it = 0; it < 5; it++) begin
      rb0 = 8'($urandom);
      rb1 = 8'($urandom);
      rb2 = 8'($urandom);
      rb3 = 8'($urandom);
      rd  = $urandom;
      do_fetch("rnd", rb0, rb1, rb2, rb3, rd, int'($urandom_range(0, 40)),
               1'($urandom_range(0, 1)), model_addr(rb0, rb1, rb2, rb3), rd);
    end

    // Reset in the middle of the second tx byte.
    idle_bits(2);
    send_byte(8'h40, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    waited = 0;
    while (mem_req !== 1'b1 && waited < 64) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("rst_tx_req", 32'(mem_req), 32'd1);
    check("rst_tx_addr", mem_addr, 32'h00000040);
    mem_ack   = 1'b1;
    mem_rdata = 32'h11223344;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    repeat (13 * CPB + 16) @(posedge clk);
    #1;
    check("rst_pre_tx", 32'(tx), 32'(model_tx_bit(32'h11223344, 13 * CPB + 15)));
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_tx", 32'(tx), 32'd1);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_req", 32'(mem_req), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_async_addr", mem_addr, 32'd0);
    reset = 1'b1;
    do_fetch("after_rst", 8'h44, 8'h33, 8'h22, 8'h11, 32'h87654321, 7, 1'b0,
             32'h11223344, 32'h87654321);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
